// File: rtl/interval_timer_pkg.sv
// Shared types and helpers for the interval timer arbiter: FSM state encoding,
// one-hot decode of an owner index and round-robin pointer advance.
package interval_timer_pkg;

  localparam int unsigned MAX_REQ = 32;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } state_t;

  // Wide result; callers cast down to their own requester count.
  function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx);
    return MAX_REQ'(1) << idx;
  endfunction

  function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/interval_timer_arbiter_rr.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/interval_timer_arbiter.sv
// One down-counting interval timer shared round-robin between NUM_REQ
// requesters; pulses the owner's done on expiry, aborts if the owner drops req.
module interval_timer_arbiter
  import interval_timer_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CNT_W   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] len,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [CNT_W-1:0]         count
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] winner;
  logic             any_req;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_rr_arbiter (
    .req   (req),
    .ptr   (ptr_q),
    .winner(winner),
    .valid (any_req)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          idx_d   = winner;
          count_d = len[32'(winner)*CNT_W +: CNT_W];
          state_d = COUNT;
        end
      end
      COUNT: begin
        // Abort wins over expiry when req drops on the zero-count cycle.
        if (!req[idx_q]) begin
          state_d = IDLE;
          ptr_d   = IDX_W'(next_ptr(32'(idx_q), NUM_REQ));
          count_d = '0;
        end else if (count_q == '0) begin
          state_d = DONE;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = IDX_W'(next_ptr(32'(idx_q), NUM_REQ));
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q == COUNT) || (state_q == DONE);
    grant = busy ? NUM_REQ'(onehot(32'(idx_q))) : '0;
    done  = (state_q == DONE) ? NUM_REQ'(onehot(32'(idx_q))) : '0;
    count = count_q;
  end

endmodule

// File: tb/tb_interval_timer_arbiter.sv
// Self-checking bench for interval_timer_arbiter: directed vector table,
// hand-written corner sequences and randomized traffic against a reference model.
module tb_interval_timer_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] len;
  logic [3:0]  grant, done;
  logic        busy;
  logic [3:0]  count;

  int n_vec  = 0;
  int n_miss = 0;

  interval_timer_arbiter #(
    .NUM_REQ(4),
    .CNT_W  (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .len  (len),
    .grant(grant),
    .done (done),
    .busy (busy),
    .count(count)
  );

  always #5 clk = ~clk;

  // Reference model: owner index (-1 when nobody holds the timer), remaining
  // ticks, whether the expiry pulse is showing, and the round-robin start point.
  int m_owner;
  int m_rem;
  bit m_fin;
  int m_ptr;

  task automatic model_reset();
    m_owner = -1;
    m_rem   = 0;
    m_fin   = 1'b0;
    m_ptr   = 0;
  endtask

  task automatic model_edge(input logic [3:0] r, input logic [15:0] l);
    bit found;
    if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (m_ptr + k) % 4;
        if (!found && r[j]) begin
          found   = 1'b1;
          m_owner = j;
          m_rem   = int'(l[j*4 +: 4]);
          m_fin   = 1'b0;
        end
      end
    end else if (m_fin) begin
      m_ptr   = (m_owner + 1) % 4;
      m_owner = -1;
      m_fin   = 1'b0;
    end else if (!r[m_owner]) begin
      m_ptr   = (m_owner + 1) % 4;
      m_owner = -1;
      m_rem   = 0;
    end else if (m_rem == 0) begin
      m_fin = 1'b1;
    end else begin
      m_rem = m_rem - 1;
    end
  endtask

  task automatic check(input string name, input logic [3:0] eg, input logic [3:0] ed,
                       input logic eb, input logic [3:0] ec);
    n_vec++;
    if ({grant, done, busy, count} !== {eg, ed, eb, ec}) begin
      n_miss++;
      $display("FAIL %s: got grant=%b done=%b busy=%b count=%0d, expected grant=%b done=%b busy=%b count=%0d",
               name, grant, done, busy, count, eg, ed, eb, ec);
    end
  endtask

  task automatic check_model(input string name);
    logic [3:0] eg, ed;
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    ed = m_fin ? eg : 4'b0000;
    check(name, eg, ed, m_owner >= 0, (m_owner >= 0) ? 4'(m_rem) : 4'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge(req, len);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    len   = '0;
    model_reset();
    tick();
    tick();
    check("reset_state", 4'b0000, 4'b0000, 1'b0, 4'd0);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [15:0] len;
    logic [3:0]  g;
    logic [3:0]  d;
    logic        b;
    logic [3:0]  c;
  } vec_t;

  vec_t tbl[17];

  initial begin
    int         owners[$];
    int         done_cnt[4];
    int         back_to_back;
    logic [3:0] prev_g;
    bit         reached;

    // single req0 len3, len2=0 single-cycle interval, len change mid-count
    tbl[0]  = '{4'b0001, 16'h0003, 4'b0001, 4'b0000, 1'b1, 4'd3};
    tbl[1]  = '{4'b0001, 16'h0003, 4'b0001, 4'b0000, 1'b1, 4'd2};
    tbl[2]  = '{4'b0001, 16'h0003, 4'b0001, 4'b0000, 1'b1, 4'd1};
    tbl[3]  = '{4'b0001, 16'h0003, 4'b0001, 4'b0000, 1'b1, 4'd0};
    tbl[4]  = '{4'b0001, 16'h0003, 4'b0001, 4'b0001, 1'b1, 4'd0};
    tbl[5]  = '{4'b0000, 16'h0003, 4'b0000, 4'b0000, 1'b0, 4'd0};
    tbl[6]  = '{4'b0000, 16'h0003, 4'b0000, 4'b0000, 1'b0, 4'd0};
    tbl[7]  = '{4'b0100, 16'h0000, 4'b0100, 4'b0000, 1'b1, 4'd0};
    tbl[8]  = '{4'b0100, 16'h0000, 4'b0100, 4'b0100, 1'b1, 4'd0};
    tbl[9]  = '{4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 4'd0};
    tbl[10] = '{4'b0001, 16'h0002, 4'b0001, 4'b0000, 1'b1, 4'd2};
    tbl[11] = '{4'b0001, 16'h0007, 4'b0001, 4'b0000, 1'b1, 4'd1};
    tbl[12] = '{4'b0001, 16'h0007, 4'b0001, 4'b0000, 1'b1, 4'd0};
    tbl[13] = '{4'b0001, 16'h0007, 4'b0001, 4'b0001, 1'b1, 4'd0};
    tbl[14] = '{4'b0001, 16'h0007, 4'b0000, 4'b0000, 1'b0, 4'd0};
    tbl[15] = '{4'b0001, 16'h0007, 4'b0001, 4'b0000, 1'b1, 4'd7};
    tbl[16] = '{4'b0000, 16'h0007, 4'b0000, 4'b0000, 1'b0, 4'd0};

    do_reset();
    for (int i = 0; i < 17; i++) begin
      req = tbl[i].req;
      len = tbl[i].len;
      tick();
      check($sformatf("table_row%0d", i), tbl[i].g, tbl[i].d, tbl[i].b, tbl[i].c);
    end

    // All four requesting, len 1 each: strict rotation with idle gaps.
    do_reset();
    req = 4'b1111;
    len = 16'h1111;
    prev_g = '0;
    back_to_back = 0;
    for (int k = 0; k < 4; k++) done_cnt[k] = 0;
    for (int i = 0; i < 18; i++) begin
      tick();
      check_model("rotate_model");
      if (grant != 0 && prev_g == 0) owners.push_back($clog2(grant));
      if (grant != 0 && prev_g != 0 && grant != prev_g) back_to_back++;
      if (i < 16)
        for (int k = 0; k < 4; k++) if (done[k]) done_cnt[k]++;
      prev_g = grant;
    end
    n_vec++;
    if (owners.size() < 5 || owners[0] != 0 || owners[1] != 1 || owners[2] != 2 ||
        owners[3] != 3 || owners[4] != 0) begin
      n_miss++;
      $display("FAIL rotate_order: got %p, expected 0 1 2 3 0", owners);
    end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (done_cnt[k] != 1) begin
        n_miss++;
        $display("FAIL rotate_done%0d: got %0d pulses, expected 1", k, done_cnt[k]);
      end
    end
    n_vec++;
    if (back_to_back != 0) begin
      n_miss++;
      $display("FAIL rotate_gap: got %0d owner switches without idle cycle, expected 0", back_to_back);
    end

    // Owner 1 aborts at count 2; ptr moves to 2 so req3 beats req0.
    do_reset();
    req = 4'b0010;
    len = 16'h0050;
    tick();
    check("abort_grant", 4'b0010, 4'b0000, 1'b1, 4'd5);
    req = 4'b1011;
    reached = 1'b0;
    for (int i = 0; i < 10 && !reached; i++) begin
      tick();
      check_model("abort_count");
      if (count == 4'd2) reached = 1'b1;
    end
    n_vec++;
    if (!reached) begin
      n_miss++;
      $display("FAIL abort_wait: got count=%0d, expected to reach 2 within 10 cycles", count);
    end
    req = 4'b1001;
    tick();
    check("abort_idle", 4'b0000, 4'b0000, 1'b0, 4'd0);
    tick();
    check("abort_next_req3", 4'b1000, 4'b0000, 1'b1, 4'd0);

    // Asynchronous reset in the middle of a count.
    do_reset();
    req = 4'b0001;
    len = 16'h0007;
    reached = 1'b0;
    for (int i = 0; i < 10 && !reached; i++) begin
      tick();
      if (count == 4'd4) reached = 1'b1;
    end
    n_vec++;
    if (!reached) begin
      n_miss++;
      $display("FAIL areset_wait: got count=%0d, expected to reach 4 within 10 cycles", count);
    end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("areset_immediate", 4'b0000, 4'b0000, 1'b0, 4'd0);
    req = 4'b1000;
    len = 16'h3000;
    tick();
    reset = 1'b0;
    tick();
    check("areset_req3_first", 4'b1000, 4'b0000, 1'b1, 4'd3);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 7) == 0) req[k] = ~req[k];
      if ($urandom_range(0, 3) == 0) len = 16'($urandom);
      tick();
      check_model("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
